code_entry: RTL

// Producer side of the game's code/enter interface: turns the raw 16-bit digit switches and the bouncy

---
 rtl/bc_pkg.sv | 51 +++++
 rtl/button_debouncer.sv | 46 ++++
 rtl/code_entry.sv | 107 ++++++++++
 3 files changed

// File: rtl/bc_pkg.sv
// Shared code/enter definitions: digit layout, entry FSM states,
// and the order in which digit pairs are compared.
package bc_pkg;

  localparam int DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
  localparam logic [2:0] LAST_PAIR = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    OFFER,
    ERROR
  } entry_state_t;

  // Returns digit i of a packed 4-digit code.
  function automatic logic [DIGIT_W-1:0] digit(
    input logic [DIGITS*DIGIT_W-1:0] code,
    input logic [1:0] i
  );
    return code[{i, 2'b00} +: DIGIT_W];
  endfunction

  // Higher digit of pair idx: (3,2)(3,1)(3,0)(2,1)(2,0)(1,0)
  function automatic logic [1:0] pair_hi(
    input logic [2:0] idx
  );
    logic [1:0] r;
    case (idx)
      3'd0, 3'd1, 3'd2: r = 2'd3;
      3'd3, 3'd4: r = 2'd2;
      default: r = 2'd1;
    endcase
    return r;
  endfunction

  // Lower digit of pair idx.
  function automatic logic [1:0] pair_lo(
    input logic [2:0] idx
  );
    logic [1:0] r;
    case (idx)
      3'd0: r = 2'd2;
      3'd1, 3'd3: r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Enter button conditioning: 2-FF synchroniser, stability
// counter, and a one-cycle pulse on the debounced rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync0;
  logic sync1;
  logic level;
  logic level_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then flip level only after a stable run.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
    end else begin
      sync0 <= button;
      sync1 <= sync0;
      level_q <= level;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_END) begin
        level <= sync1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/code_entry.sv
// Validates a 4-digit BCD code on an enter press and offers
// it to the game FSM by valid/ready.
module code_entry
  import bc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sw_code,
  input  logic        enter_button,
  input  logic        game_ready,
  output logic        code_valid,
  output logic [15:0] code_out,
  output logic        code_error,
  output logic        err_range,
  output logic        err_repeat,
  output logic        busy
);

  entry_state_t state;
  entry_state_t state_n;
  logic press;
  logic [15:0] snap;
  logic [2:0] idx;
  logic range_hit;
  logic pair_hit;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clock (clock),
    .reset (reset),
    .button(enter_button),
    .press (press)
  );

  // Per-cycle checks: all digits on the first pair, one pair each cycle.
  always_comb begin
    range_hit = 1'b0;
    if (idx == 3'd0) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (digit(snap, 2'(i)) > MAX_DIGIT) range_hit = 1'b1;
      end
    end
    pair_hit = digit(snap, pair_hi(idx)) == digit(snap, pair_lo(idx));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (press) state_n = CHECK;
      CHECK: begin
        if (idx == LAST_PAIR) begin
          if (err_range | err_repeat | range_hit | pair_hit)
            state_n = ERROR;
          else
            state_n = OFFER;
        end
      end
      OFFER: if (game_ready) state_n = IDLE;
      ERROR: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Snapshot, pair walk, sticky error flags and accepted code.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap <= '0;
      idx <= '0;
      err_range <= 1'b0;
      err_repeat <= 1'b0;
      code_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            snap <= sw_code;
            idx <= '0;
            err_range <= 1'b0;
            err_repeat <= 1'b0;
          end
        end
        CHECK: begin
          idx <= idx + 1'b1;
          if (range_hit) err_range <= 1'b1;
          if (pair_hit) err_repeat <= 1'b1;
          if (state_n == OFFER) code_out <= snap;
        end
        default: ;
      endcase
    end
  end

  assign code_valid = state == OFFER;
  assign code_error = state == ERROR;
  assign busy = state != IDLE;

endmodule
